// File: rtl/mesh_driver.sv
// Edge-terminal stimulus driver for the mesh_gnrtr router mesh: accepts agent transactions,
// drops those addressed to non-terminals, and queues legal packets in a fall-through FIFO.
module mesh_driver #(
  parameter int ROWS       = 2,
  parameter int COLUMS     = 2,
  parameter int pckg_sz    = 20,
  parameter int fifo_depth = 4,
  parameter int DRV_ID     = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [7:0]                      in_nxt_jump,
  input  logic [3:0]                      in_id_row,
  input  logic [3:0]                      in_id_col,
  input  logic                            in_mode,
  input  logic [pckg_sz-18:0]             in_dato,
  output logic [pckg_sz-1:0]              data_out_i_in,
  output logic                            pndng_i_in,
  input  logic                            popin,
  output logic [$clog2(fifo_depth+1)-1:0] count,
  output logic                            bad_dest,
  output logic [15:0]                     sent_cnt,
  output logic [7:0]                      drv_id
);

  localparam int CW = $clog2(fifo_depth + 1);
  localparam int PW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam logic [3:0] ROW_LAST = 4'(ROWS + 1);
  localparam logic [3:0] COL_LAST = 4'(COLUMS + 1);
  localparam logic [3:0] ROW_MAX  = 4'(ROWS);
  localparam logic [3:0] COL_MAX  = 4'(COLUMS);

  logic [pckg_sz-1:0] mem [fifo_depth];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count_nxt;
  logic [pckg_sz-1:0] pkt;
  logic               full;
  logic               pop;
  logic               accept;
  logic               legal;
  logic               wr;

  // Only terminals on the mesh rim (excluding the four corners) are reachable targets.
  function automatic logic is_terminal(input logic [3:0] row, input logic [3:0] col);
    logic edge_row;
    logic edge_col;
    edge_row = ((row == 4'd0) || (row == ROW_LAST)) && (col >= 4'd1) && (col <= COL_MAX);
    edge_col = ((col == 4'd0) || (col == COL_LAST)) && (row >= 4'd1) && (row <= ROW_MAX);
    return edge_row || edge_col;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    if (ptr == PW'(fifo_depth - 1)) return '0;
    return ptr + PW'(1);
  endfunction

  assign drv_id   = 8'(DRV_ID);
  assign pkt      = {in_nxt_jump, in_id_row, in_id_col, in_mode, in_dato};
  assign full     = (count == CW'(fifo_depth));
  assign pop      = popin && pndng_i_in;
  assign in_ready = reset && (!full || pop);
  assign accept   = in_valid && in_ready;
  assign legal    = is_terminal(in_id_row, in_id_col);
  assign wr       = accept && legal;

  always_comb begin
    count_nxt = count;
    if (wr && !pop) count_nxt = count + CW'(1);
    else if (pop && !wr) count_nxt = count - CW'(1);
  end

  // Storage stage: data only, no reset needed since reads are gated by pndng_i_in.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= pkt;
  end

  // Control stage: pointers, occupancy and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pndng_i_in <= 1'b0;
      bad_dest   <= 1'b0;
      sent_cnt   <= '0;
    end else begin
      if (wr) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        sent_cnt <= sent_cnt + 16'd1;
      end
      count      <= count_nxt;
      pndng_i_in <= (count_nxt != '0);
      bad_dest   <= accept && !legal;
    end
  end

  assign data_out_i_in = pndng_i_in ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_mesh_driver.sv
// Randomized scoreboard bench for mesh_driver against a queue-based packet model.
module tb_mesh_driver;
  localparam int ROWS = 2;
  localparam int COLUMS = 2;
  localparam int PK = 20;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_nxt_jump;
  logic [3:0]    in_id_row;
  logic [3:0]    in_id_col;
  logic          in_mode;
  logic [PK-18:0] in_dato;
  logic [PK-1:0] data_out_i_in;
  logic          pndng_i_in;
  logic          popin;
  logic [2:0]    count;
  logic          bad_dest;
  logic [15:0]   sent_cnt;
  logic [7:0]    drv_id;

  int n_cmp = 0;
  int n_bad = 0;
  logic [PK-1:0] mq[$];
  logic [PK-1:0] pop_q[$];
  int  msent = 0;
  bit  exp_bad = 0;

  mesh_driver #(.ROWS(ROWS), .COLUMS(COLUMS), .pckg_sz(PK), .fifo_depth(D), .DRV_ID(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_nxt_jump(in_nxt_jump), .in_id_row(in_id_row), .in_id_col(in_id_col),
    .in_mode(in_mode), .in_dato(in_dato), .data_out_i_in(data_out_i_in),
    .pndng_i_in(pndng_i_in), .popin(popin), .count(count), .bad_dest(bad_dest),
    .sent_cnt(sent_cnt), .drv_id(drv_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit legal(input int r, input int c);
    bit on_row_edge = (r == 0 || r == ROWS + 1) && c >= 1 && c <= COLUMS;
    bit on_col_edge = (c == 0 || c == COLUMS + 1) && r >= 1 && r <= ROWS;
    return on_row_edge || on_col_edge;
  endfunction

  task automatic check_state();
    logic [PK-1:0] head;
    head = (mq.size() != 0) ? mq[0] : '0;
    chk("count", 32'(count), 32'(mq.size()));
    chk("pndng", 32'(pndng_i_in), 32'(mq.size() != 0));
    chk("head", 32'(data_out_i_in), 32'(head));
    chk("sent_cnt", 32'(sent_cnt), 32'(msent % 65536));
    chk("bad_dest", 32'(bad_dest), 32'(exp_bad));
  endtask

  task automatic step(input bit v, input logic [7:0] nj, input logic [3:0] r, input logic [3:0] c,
                      input logic m, input logic [2:0] d, input bit p);
    int pre;
    bit rdy;
    bit do_pop;
    @(negedge clk);
    check_state();
    in_valid = v; in_nxt_jump = nj; in_id_row = r; in_id_col = c;
    in_mode = m; in_dato = d; popin = p;
    #1;
    pre = mq.size();
    do_pop = p && pre > 0;
    rdy = (pre < D) || do_pop;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    if (do_pop) begin
      pop_q.push_back(mq.pop_front());
      msent++;
    end
    exp_bad = 0;
    if (v && rdy) begin
      if (legal(int'(r), int'(c))) mq.push_back({nj, r, c, m, d});
      else exp_bad = 1;
    end
  endtask

  task automatic idle();
    step(0, 8'h0, 4'h0, 4'h0, 1'b0, 3'h0, 0);
  endtask

  // Scoreboard monitor: whenever the DUT presents a pop handshake, compare the head it shows.
  always @(negedge clk) begin
    #2;
    if (reset === 1'b1 && popin === 1'b1 && pndng_i_in === 1'b1) begin
      if (pop_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL pop_data: DUT popped %0h but no pop was expected", data_out_i_in);
      end else begin
        chk("pop_data", 32'(data_out_i_in), 32'(pop_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0; in_valid = 0; in_nxt_jump = 0; in_id_row = 0; in_id_col = 0;
    in_mode = 0; in_dato = 0; popin = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    chk("drv_id", 32'(drv_id), 32'h0);

    // Reset state and single packet
    idle();
    step(1, 8'h00, 4'd0, 4'd1, 1'b1, 3'b101, 0);
    idle();
    step(0, 8'h00, 4'd0, 4'd0, 1'b0, 3'b000, 1);
    idle();

    // Fill to full, held push, then push+pop in the same cycle
    for (int i = 0; i < D; i++) step(1, 8'(8'hA0 + i), 4'd3, 4'd2, 1'b0, 3'(i), 0);
    step(1, 8'hEE, 4'd1, 4'd0, 1'b1, 3'd7, 0);
    step(1, 8'hEF, 4'd2, 4'd3, 1'b1, 3'd6, 1);
    idle();
    for (int i = 0; i < D + 1; i++) step(0, 8'h0, 4'd0, 4'd0, 1'b0, 3'd0, 1);
    idle();

    // Ordering
    for (int i = 1; i <= 3; i++) step(1, 8'h55, 4'd0, 4'd2, 1'b0, 3'(i), 0);
    for (int i = 0; i < 3; i++) step(0, 8'h0, 4'd0, 4'd0, 1'b0, 3'd0, 1);
    idle();

    // Illegal destinations: interior and corner
    step(1, 8'h11, 4'd1, 4'd1, 1'b0, 3'd1, 0);
    step(1, 8'h22, 4'd3, 4'd3, 1'b1, 3'd2, 0);
    step(1, 8'h33, 4'd0, 4'd0, 1'b1, 3'd3, 0);
    idle();

    // Pop on empty
    for (int i = 0; i < 5; i++) step(0, 8'h0, 4'd0, 4'd0, 1'b0, 3'd0, 1);
    idle();

    // Reset mid-stream
    for (int i = 0; i < 3; i++) step(1, 8'(i), 4'd1, 4'd3, 1'b0, 3'(i), 0);
    @(posedge clk);
    #3;
    in_valid = 0; popin = 0;
    reset = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_pndng", 32'(pndng_i_in), 32'h0);
    chk("rst_data", 32'(data_out_i_in), 32'h0);
    chk("rst_sent", 32'(sent_cnt), 32'h0);
    mq.delete(); pop_q.delete(); msent = 0; exp_bad = 0;
    @(negedge clk);
    reset = 1'b1;
    step(1, 8'h77, 4'd2, 4'd0, 1'b1, 3'd5, 0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 9) < 7, 8'($urandom), 4'($urandom_range(0, 4)),
           4'($urandom_range(0, 4)), 1'($urandom), 3'($urandom), 1'($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < D + 2; i++) step(0, 8'h0, 4'd0, 4'd0, 1'b0, 3'd0, 1);
    idle();
    idle();
    chk("pops_outstanding", 32'(pop_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
